// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle datapath sequencer.
// Optional HALT support is enabled by defining CPU_SEQ_HALT_EN.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_WAIT, S_GET_A, S_GET_B, S_GET_D,
    S_ALU, S_PASS, S_ADDR, S_LADDR,
    S_STATUS, S_WB_IMM, S_WB_C, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_HALTED
  } state_t;

  localparam logic [4:0] OP_MOVI = 5'b11010;
  localparam logic [4:0] OP_MOVR = 5'b11000;
  localparam logic [4:0] OP_ADD  = 5'b10100;
  localparam logic [4:0] OP_CMP  = 5'b10101;
  localparam logic [4:0] OP_AND  = 5'b10110;
  localparam logic [4:0] OP_MVN  = 5'b10111;
  localparam logic [4:0] OP_LDR  = 5'b01100;
  localparam logic [4:0] OP_STR  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11100;

  localparam logic [1:0] RS_RM = 2'b00;
  localparam logic [1:0] RS_RD = 2'b01;
  localparam logic [1:0] RS_RN = 2'b10;

  localparam logic [1:0] WBS_C   = 2'b00;
  localparam logic [1:0] WBS_IMM = 2'b10;
  localparam logic [1:0] WBS_MEM = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam int MEM_LAT_MAX = 7;

  typedef struct packed {
    logic       waiting;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_a;
    logic       en_b;
    logic       en_c;
    logic       en_status;
    logic       sel_a;
    logic       sel_b;
    logic       load_addr;
    logic [1:0] mem_cmd;
  } ctrl_t;

  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    c.mem_cmd = MEM_NONE;
    case (s)
      S_WAIT:   c.waiting = 1'b1;
      S_GET_A:  begin c.reg_sel = RS_RN; c.en_a = 1'b1; end
      S_GET_B:  begin c.reg_sel = RS_RM; c.en_b = 1'b1; end
      S_GET_D:  begin c.reg_sel = RS_RD; c.en_b = 1'b1; end
      S_ALU:    c.en_c = 1'b1;
      S_PASS:   begin c.en_c = 1'b1; c.sel_a = 1'b1; end
      S_ADDR:   begin c.en_c = 1'b1; c.sel_b = 1'b1; end
      S_LADDR:  c.load_addr = 1'b1;
      S_STATUS: c.en_status = 1'b1;
      S_WB_IMM: begin
        c.reg_sel = RS_RN; c.wb_sel = WBS_IMM; c.w_en = 1'b1;
      end
      S_WB_C: begin
        c.reg_sel = RS_RD; c.wb_sel = WBS_C; c.w_en = 1'b1;
      end
      S_MEM_RD: c.mem_cmd = MEM_READ;
      S_WB_MEM: begin
        c.mem_cmd = MEM_READ; c.reg_sel = RS_RD;
        c.wb_sel = WBS_MEM; c.w_en = 1'b1;
      end
      S_MEM_WR: c.mem_cmd = MEM_WRITE;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable 3-bit down-counter timing the memory read wait.
module lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [2:0] value,
  output logic       done
);

  logic [2:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (dec && count != 3'd0)
      count <= count - 3'd1;
  end

  assign done = (count == 3'd0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the register/ALU datapath with LDR/STR.
// Define CPU_SEQ_HALT_EN to make encoding 11100 a reset-only HALT.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  output logic       waiting,
  output logic       illegal,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_addr,
  output logic [1:0] mem_cmd
);

  localparam int LAT = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                       (MEM_LAT < 0) ? 0 : MEM_LAT;
  localparam logic [2:0] LAT_M1 = (LAT == 0) ? 3'd0 : 3'(LAT - 1);

  state_t     state, nxt;
  ctrl_t      ctl;
  logic [4:0] instr, enc;
  logic       cnt_done, cnt_load, cnt_dec;

  assign enc = {opcode, ALU_op};

  always_comb begin
    nxt = state;
    case (state)
      S_WAIT: if (start) begin
        case (enc)
          OP_MOVI:                 nxt = S_WB_IMM;
          OP_MOVR, OP_MVN:         nxt = S_GET_B;
          OP_ADD, OP_AND, OP_CMP,
          OP_LDR, OP_STR:          nxt = S_GET_A;
`ifdef CPU_SEQ_HALT_EN
          OP_HALT:                 nxt = S_HALTED;
`endif
          default:                 nxt = S_WAIT;
        endcase
      end
      S_GET_A:
        nxt = (instr == OP_LDR || instr == OP_STR) ? S_ADDR : S_GET_B;
      S_GET_B: begin
        case (instr)
          OP_CMP:         nxt = S_STATUS;
          OP_ADD, OP_AND: nxt = S_ALU;
          default:        nxt = S_PASS;
        endcase
      end
      S_ALU:    nxt = S_WB_C;
      S_PASS:   nxt = (instr == OP_STR) ? S_MEM_WR : S_WB_C;
      S_ADDR:   nxt = S_LADDR;
      S_LADDR: begin
        if (instr == OP_STR) nxt = S_GET_D;
        else if (LAT == 0)   nxt = S_WB_MEM;
        else                 nxt = S_MEM_RD;
      end
      S_GET_D:  nxt = S_PASS;
      S_MEM_RD: nxt = cnt_done ? S_WB_MEM : S_MEM_RD;
      S_HALTED: nxt = S_HALTED;
      default:  nxt = S_WAIT;
    endcase
  end

  // Outputs are registered from the next state, so they stay Moore.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_WAIT;
      instr   <= '0;
      illegal <= 1'b0;
      ctl     <= decode(S_WAIT);
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
      if (state == S_WAIT && start) begin
        instr   <= enc;
        illegal <= (nxt == S_WAIT);
      end
    end
  end

  assign cnt_load = (state == S_LADDR) && (nxt == S_MEM_RD);
  assign cnt_dec  = (state == S_MEM_RD);

  lat_counter u_lat (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (LAT_M1),
    .done  (cnt_done)
  );

  assign waiting   = ctl.waiting;
  assign reg_sel   = ctl.reg_sel;
  assign wb_sel    = ctl.wb_sel;
  assign w_en      = ctl.w_en;
  assign en_A      = ctl.en_a;
  assign en_B      = ctl.en_b;
  assign en_C      = ctl.en_c;
  assign en_status = ctl.en_status;
  assign sel_A     = ctl.sel_a;
  assign sel_B     = ctl.sel_b;
  assign load_addr = ctl.load_addr;
  assign mem_cmd   = ctl.mem_cmd;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multi-cycle control FSM for the simple register/ALU datapath: accepts one decoded instruction per `start`/`waiting` handshake and sequences register-file reads, ALU, status capture, write-back and memory accesses. It sits between the instruction register/decoder and the datapath plus memory interface. Next generation of the datapath controller: adds LDR/STR, configurable memory read latency, illegal-instruction flagging and an optional HALT.

## Interface
- `MEM_LAT`, default 1: memory read wait cycles, legal range 0..7.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request to execute the instruction on `opcode`/`ALU_op`.
- `opcode` in 3: instruction class.
- `ALU_op` in 2: sub-op.
- `waiting` out 1: idle and ready for `start`.
- `illegal` out 1: sticky flag, last accepted encoding was unsupported.
- `reg_sel` out 2: register-file select. 00=Rm, 01=Rd, 10=Rn.
- `wb_sel` out 2: write-back source. 00=C, 10=sximm8, 11=mdata.
- `w_en` out 1: register-file write.
- `en_A`, `en_B`, `en_C`, `en_status` out 1 each: datapath register loads.
- `sel_A` out 1: 1 = zero into ALU A.
- `sel_B` out 1: 1 = sximm5 into ALU B.
- `load_addr` out 1: latch C into the address register.
- `mem_cmd` out 2: 00=NONE, 01=READ, 10=WRITE.

## Operation
- Instruction {opcode,ALU_op} is latched on the `start` edge in WAIT; `start` is ignored in every other state.
- Outputs are Moore, decoded from the current state. Any output not listed for a state is 0. `waiting` is 1 only in WAIT.
- State output sets:
  - GET_A: `reg_sel`=Rn, `en_A`.
  - GET_B: Rm, `en_B`.
  - GET_D: Rd, `en_B`.
  - ALU: `en_C`, `sel_A`=0.
  - PASS: `en_C`, `sel_A`=1.
  - ADDR: `en_C`, `sel_B`=1.
  - LADDR: `load_addr`.
  - STATUS: `en_status`.
  - WB_IMM: Rn, `wb_sel`=10, `w_en`.
  - WB_C: Rd, 00, `w_en`.
  - MEM_RD: READ.
  - WB_MEM: READ, Rd, 11, `w_en`.
  - MEM_WR: WRITE.
- Sequences, each ending by returning to WAIT:
  - MOV imm (11010): WB_IMM.
  - MOV reg (11000): GET_B, PASS, WB_C.
  - ADD (10100) and AND (10110): GET_A, GET_B, ALU, WB_C.
  - CMP (10101): GET_A, GET_B, STATUS.
  - MVN (10111): GET_B, PASS, WB_C.
  - LDR (01100): GET_A, ADDR, LADDR, MEM_RD×`MEM_LAT`, WB_MEM. MEM_RD is skipped when `MEM_LAT`=0.
  - STR (10000): GET_A, ADDR, LADDR, GET_D, PASS, MEM_WR.
- Any other encoding: no datapath activity. `illegal` is set and the FSM stays in WAIT. `illegal` clears on the next accepted `start` with a legal encoding.
- The MEM_RD latency counter is a 3-bit down-counter. It loads `MEM_LAT`-1 on entry and exits when it reaches 0.

## Timing
- Reset (async, any state, mid-instruction included):
  - FSM goes to WAIT, `waiting`=1, every other output 0.
  - The latched instruction, the latency counter and `illegal` are cleared.
  - Any in-flight write or memory command is abandoned.
- Handshake: `start` is sampled at edge T in WAIT, and `waiting` is 0 from T until the sequence's last state completes.
- Cycles with `waiting`=0: MOV imm 1, MOV 3, MVN 3, CMP 3, ADD/AND 4, LDR 4+`MEM_LAT`, STR 6.
- `start` held high continuously: a new instruction is accepted on the first edge back in WAIT. No idle cycle beyond the one WAIT cycle.
- `mem_cmd` is held at READ from the first MEM_RD cycle through WB_MEM, so mdata is stable at write-back.

## Configuration
- `CPU_SEQ_HALT_EN` defined:
  - Encoding 11100 enters HALTED. All outputs are 0, including `waiting`, and `start` is ignored.
  - Only `rst` exits HALTED.
- Not defined: 11100 is illegal and handled as above.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - the 5-bit instruction encodings;
  - the `reg_sel`, `wb_sel` and `mem_cmd` encoding constants;
  - the `MEM_LAT` range check constant.
- Sub-module `lat_counter`: the loadable 3-bit down-counter with a `done` output. It is the only sub-module.

## Test plan
- Reset asserted mid-ADD (during ALU) → same cycle: `waiting`=1, `w_en`=0, `en_C`=0; a subsequent MOV imm executes normally.
- ADD (10100) → `waiting` low for exactly 4 cycles. Order: `en_A`(Rn), `en_B`(Rm), `en_C` (`sel_A`=0, `sel_B`=0), `w_en` (Rd, `wb_sel`=00).
- CMP (10101) → `en_status` for one cycle in the 3rd busy cycle; `w_en` never asserted.
- LDR with `MEM_LAT`=3, then `MEM_LAT`=0 → busy 7 cycles then 4 cycles; `mem_cmd`=READ for 4 and 1 cycles respectively, ending on the `w_en` cycle with `wb_sel`=11.
- STR → `load_addr` in cycle 3, `reg_sel`=Rd with `en_B` in cycle 4, `mem_cmd`=WRITE only in cycle 6, no `w_en`.
- Encoding 00100 → `illegal`=1, `waiting` stays 1. Next MOV imm clears `illegal`. With `CPU_SEQ_HALT_EN`, 11100 → `waiting`=0 indefinitely until `rst`.
